nv_ram_rwsp_256x16_fifo_ctrl: RTL and testbench

- Valid/ready FIFO controller that drives a 256x16 two-port RAM macro.
- The macro has a registered read address (loaded on re) and a registered output (loaded on ore).
- This block generates all RAM write and read controls and absorbs the 2-cycle read latency with a small output skid buffer.
- It gives upstream and downstream logic a 16-bit stream with full backpressure and 1 word/cycle sustained throughput.

---
 rtl/nv_ram_rwsp_256x16_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_nv_ram_rwsp_256x16_fifo_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rwsp_256x16_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// nv_ram_rwsp_256x16_fifo_ctrl
//
// FIFO controller for a 256x16 two-port RAM macro. The macro has a registered
// read address (loaded on ram_re) and a registered data output (loaded on
// ram_ore). The controller generates all RAM controls and hides the 2-cycle
// read latency behind a small register skid buffer at the output. Sustained
// throughput is one word per cycle in each direction.
//
// Ports
//   clk, rst           core clock; synchronous active-high reset
//   in_valid/in_ready  upstream handshake, in_pd is the 16-bit word
//   out_valid/out_ready downstream handshake, out_pd is the skid head word
//   ram_we/ram_wa/ram_di   RAM write port (combinational)
//   ram_re/ram_ra          RAM read-address load (combinational)
//   ram_ore                RAM output-register load (registered)
//   ram_dout               RAM registered output
//   fifo_count             words held (RAM + read pipeline + skid), registered
//
// Handshake: on both streams a word moves on a rising clk edge where valid
// and ready are both high. Neither valid nor ready waits on the other side's
// signal; in_ready depends only on rst and pointer state, out_valid only on
// the skid occupancy register.
// ---------------------------------------------------------------------------
module nv_ram_rwsp_256x16_fifo_ctrl #(
  parameter int SKID_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_pd,
  output logic [7:0]  ram_wa,
  output logic        ram_we,
  output logic [15:0] ram_di,
  output logic [7:0]  ram_ra,
  output logic        ram_re,
  output logic        ram_ore,
  input  logic [15:0] ram_dout,
  output logic [8:0]  fifo_count
);

  localparam int OW = $clog2(SKID_DEPTH + 1);

  // Pointers carry a wrap bit above the 8-bit RAM address.
  logic [8:0]    wr_q, wr_d;   // next slot to write
  logic [8:0]    rd_q, rd_d;   // next slot to issue a read for
  logic [8:0]    cm_q, cm_d;   // next slot to be captured by ore (frees it)
  logic          ore_q;        // ram_re delayed one cycle
  logic          cap_q;        // ram_ore delayed one cycle: ram_dout is valid
  logic [OW-1:0] occ_q, occ_d;
  logic [15:0]   skid_q [SKID_DEPTH];
  logic [15:0]   skid_d [SKID_DEPTH];
  logic [8:0]    cnt_q, cnt_d;

  logic [8:0]    ram_used;
  logic [OW:0]   skid_fill;
  logic          wr_en, rd_en, push, pop;

  // A slot stays occupied until ore has copied it into the output register,
  // so the write side is limited by cm_q, not rd_q.
  assign ram_used  = wr_q - cm_q;
  assign in_ready  = !rst && (ram_used < 9'd256);
  assign wr_en     = in_valid && in_ready;

  assign out_valid = (occ_q != '0);
  assign out_pd    = skid_q[0];
  assign pop       = out_valid && out_ready;
  assign push      = cap_q;

  // Skid space is reserved at issue time for every read still in the
  // pipeline, so a capture can never find the buffer full.
  assign skid_fill = {1'b0, occ_q} + (OW+1)'(ore_q) + (OW+1)'(cap_q);
  assign rd_en     = !rst && (rd_q != wr_q) &&
                     ((skid_fill < (OW+1)'(SKID_DEPTH)) || pop);

  assign ram_we     = wr_en;
  assign ram_wa     = wr_en ? wr_q[7:0] : 8'd0;
  assign ram_di     = wr_en ? in_pd : 16'd0;
  assign ram_re     = rd_en;
  assign ram_ra     = rd_en ? rd_q[7:0] : 8'd0;
  assign ram_ore    = ore_q;
  assign fifo_count = cnt_q;

  assign wr_d = wr_q + 9'(wr_en);
  assign rd_d = rd_q + 9'(rd_en);
  assign cm_d = cm_q + 9'(ore_q);

  // Skid buffer: entry 0 is the head; a pop shifts toward the head and a
  // push lands just behind the last occupied entry after any shift.
  always_comb begin
    skid_d = skid_q;
    occ_d  = occ_q;
    if (pop) begin
      for (int i = 0; i < SKID_DEPTH - 1; i++) skid_d[i] = skid_q[i + 1];
      occ_d = occ_q - OW'(1);
    end
    if (push) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        if (OW'(i) == occ_d) skid_d[i] = ram_dout;
      end
      occ_d = occ_d + OW'(1);
    end
  end

  // The word sitting in the RAM output register (between ore and capture)
  // is counted too, so the count only moves on accepts and pops.
  assign cnt_d = (wr_d - cm_d) + 9'(occ_d) + 9'(ore_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cm_q  <= '0;
      ore_q <= 1'b0;
      cap_q <= 1'b0;
      occ_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_q[i] <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cm_q   <= cm_d;
      ore_q  <= rd_en;
      cap_q  <= ore_q;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsp_256x16_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for nv_ram_rwsp_256x16_fifo_ctrl. A behavioural RAM macro is
// attached; the reference is a plain queue of accepted words: every pop must
// match the queue head and fifo_count must equal the number of words
// accepted minus words popped before the current cycle.
// ---------------------------------------------------------------------------
module tb_nv_ram_rwsp_256x16_fifo_ctrl;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_pd, out_pd;
  logic [7:0]  ram_wa, ram_ra;
  logic        ram_we, ram_re, ram_ore;
  logic [15:0] ram_di, ram_dout;
  logic [8:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  // Values sampled mid-cycle by observe()
  logic        o_acc, o_pop, o_in_ready, o_out_valid, o_we, o_re, o_ore;
  logic [15:0] o_pd, o_exp, o_di;
  logic [7:0]  o_wa, o_ra;
  logic [8:0]  o_cnt, o_cnt_exp;

  nv_ram_rwsp_256x16_fifo_ctrl #(.SKID_DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pd(in_pd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pd(out_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
    .ram_dout(ram_dout), .fifo_count(fifo_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM macro model ----------------
  logic [15:0] mem [256];
  logic [7:0]  mem_ra_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  mem_ra_q <= ram_ra;
    if (ram_ore) ram_dout <= mem[mem_ra_q];
  end

  // ---------------- driver ----------------
  // Called 1 time unit after a rising edge with inputs already driven:
  // samples outputs, updates the reference queue, advances one cycle.
  task automatic observe();
    #2;
    o_in_ready  = in_ready;
    o_out_valid = out_valid;
    o_pd        = out_pd;
    o_we        = ram_we;
    o_wa        = ram_wa;
    o_di        = ram_di;
    o_re        = ram_re;
    o_ra        = ram_ra;
    o_ore       = ram_ore;
    o_cnt       = fifo_count;
    o_cnt_exp   = 9'(exp_q.size());
    o_acc       = in_valid && in_ready;
    o_pop       = out_valid && out_ready;
    o_exp       = 16'hxxxx;
    if (o_pop === 1'b1 && exp_q.size() > 0) o_exp = exp_q.pop_front();
    if (o_acc === 1'b1) exp_q.push_back(in_pd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) observe();
    exp_q.delete();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_pd = 16'hFFFF; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      observe();
      n_tests++;
      if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", o_in_ready); end
    end
    exp_q.delete();
    rst = 1'b0; in_valid = 1'b0;
    observe();
    n_tests += 9;
    if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", o_out_valid); end
    if (o_cnt !== 9'd0)       begin n_fail++; $display("FAIL rst_count: got %0d want 0", o_cnt); end
    if (o_re !== 1'b0)        begin n_fail++; $display("FAIL rst_re: got %b want 0", o_re); end
    if (o_ore !== 1'b0)       begin n_fail++; $display("FAIL rst_ore: got %b want 0", o_ore); end
    if (o_we !== 1'b0)        begin n_fail++; $display("FAIL rst_we: got %b want 0", o_we); end
    if (o_wa !== 8'd0)        begin n_fail++; $display("FAIL rst_wa: got %0h want 0", o_wa); end
    if (o_ra !== 8'd0)        begin n_fail++; $display("FAIL rst_ra: got %0h want 0", o_ra); end
    if (o_di !== 16'd0)       begin n_fail++; $display("FAIL rst_di: got %0h want 0", o_di); end
    if (o_in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", o_in_ready); end
  endtask

  task automatic test_single();
    do_reset(2);
    for (int c = 0; c < 7; c++) begin
      in_valid = (c == 0); in_pd = 16'hA5A5; out_ready = 1'b1;
      observe();
      n_tests += 5;
      if (o_we !== (c == 0))  begin n_fail++; $display("FAIL single_we c%0d: got %b want %b", c, o_we, c == 0); end
      if (o_re !== (c == 1))  begin n_fail++; $display("FAIL single_re c%0d: got %b want %b", c, o_re, c == 1); end
      if (o_ore !== (c == 2)) begin n_fail++; $display("FAIL single_ore c%0d: got %b want %b", c, o_ore, c == 2); end
      if (o_out_valid !== (c == 4)) begin n_fail++; $display("FAIL single_out_valid c%0d: got %b want %b", c, o_out_valid, c == 4); end
      if (o_cnt !== ((c >= 1 && c <= 4) ? 9'd1 : 9'd0)) begin
        n_fail++; $display("FAIL single_count c%0d: got %0d want %0d", c, o_cnt, (c >= 1 && c <= 4));
      end
      if (c == 0) begin
        n_tests += 2;
        if (o_wa !== 8'd0)      begin n_fail++; $display("FAIL single_wa: got %0h want 0", o_wa); end
        if (o_di !== 16'hA5A5)  begin n_fail++; $display("FAIL single_di: got %0h want a5a5", o_di); end
      end
      if (c == 1) begin
        n_tests++;
        if (o_ra !== 8'd0)      begin n_fail++; $display("FAIL single_ra: got %0h want 0", o_ra); end
      end
      if (c == 4) begin
        n_tests++;
        if (o_pd !== 16'hA5A5)  begin n_fail++; $display("FAIL single_pd: got %0h want a5a5", o_pd); end
      end
    end
  endtask

  task automatic test_stream();
    int sent = 0, got = 0, first = -1, cyc = 0;
    out_ready = 1'b1;
    while (got < 1000 && cyc < 1100) begin
      in_valid = (sent < 1000); in_pd = 16'(sent);
      observe();
      if (o_acc) sent++;
      n_tests += 2;
      if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc%0d: got %b want 1", cyc, o_in_ready); end
      if (o_cnt !== o_cnt_exp || o_cnt > 9'd5) begin
        n_fail++; $display("FAIL stream_count cyc%0d: got %0d want %0d (<=5)", cyc, o_cnt, o_cnt_exp);
      end
      if (o_pop) begin
        n_tests++;
        if (o_pd !== o_exp) begin n_fail++; $display("FAIL stream_data: got %0h want %0h", o_pd, o_exp); end
        got++;
        if (first < 0) first = cyc;
      end else if (first >= 0) begin
        n_tests++;
        n_fail++; $display("FAIL stream_bubble cyc%0d: got out_valid %b want 1", cyc, o_out_valid);
      end
      cyc++;
    end
    n_tests += 2;
    if (got != 1000) begin n_fail++; $display("FAIL stream_words: got %0d want 1000", got); end
    if (first != 4)  begin n_fail++; $display("FAIL stream_latency: got %0d want 4", first); end
  endtask

  task automatic test_fill();
    int acc = 0, budget = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 280; c++) begin
      in_pd = 16'(acc);
      observe();
      n_tests += 2;
      if (o_in_ready !== (acc < 259)) begin n_fail++; $display("FAIL fill_in_ready acc%0d: got %b want %b", acc, o_in_ready, acc < 259); end
      if (o_cnt !== o_cnt_exp) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", o_cnt, o_cnt_exp); end
      if (o_acc) acc++;
    end
    n_tests++;
    if (acc != 259) begin n_fail++; $display("FAIL fill_accepts: got %0d want 259", acc); end
    in_valid = 1'b0;
    observe();
    n_tests += 2;
    if (o_cnt !== 9'd259)     begin n_fail++; $display("FAIL full_count: got %0d want 259", o_cnt); end
    if (o_in_ready !== 1'b0)  begin n_fail++; $display("FAIL full_in_ready: got %b want 0", o_in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      observe();
      n_tests += 2;
      if (o_in_ready !== (c == 2)) begin n_fail++; $display("FAIL free_in_ready c%0d: got %b want %b", c, o_in_ready, c == 2); end
      if (o_pd !== 16'(c))         begin n_fail++; $display("FAIL free_data c%0d: got %0h want %0h", c, o_pd, c); end
    end
    while (exp_q.size() > 0 && budget < 400) begin
      observe();
      budget++;
      if (o_pop) begin
        n_tests++;
        if (o_pd !== o_exp) begin n_fail++; $display("FAIL fill_drain_data: got %0h want %0h", o_pd, o_exp); end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL fill_drain_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int budget = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 270; c++) begin
      in_pd = 16'($urandom);
      observe();
    end
    n_tests++;
    if (exp_q.size() != 259) begin n_fail++; $display("FAIL b2b_prefill: got %0d want 259", exp_q.size()); end
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      in_pd = 16'($urandom);
      observe();
      n_tests += 3;
      if (o_acc !== (c >= 2)) begin n_fail++; $display("FAIL b2b_accept c%0d: got %b want %b", c, o_acc, c >= 2); end
      if (o_pd !== o_exp)     begin n_fail++; $display("FAIL b2b_data c%0d: got %0h want %0h", c, o_pd, o_exp); end
      if (o_cnt !== o_cnt_exp) begin n_fail++; $display("FAIL b2b_count c%0d: got %0d want %0d", c, o_cnt, o_cnt_exp); end
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0 && budget < 400) begin
      observe();
      budget++;
      if (o_pop) begin
        n_tests++;
        if (o_pd !== o_exp) begin n_fail++; $display("FAIL b2b_drain_data: got %0h want %0h", o_pd, o_exp); end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int sent = 0, got = 0, reads = 0, wa_wraps = 0, ra_wraps = 0, cyc = 0;
    do_reset(2);
    while (got < 600 && cyc < 5000) begin
      in_valid  = (sent < 600) && ($urandom_range(0, 3) != 0);
      in_pd     = 16'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
      observe();
      n_tests++;
      if (o_cnt !== o_cnt_exp) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", o_cnt, o_cnt_exp); end
      if (o_acc) begin
        n_tests += 2;
        if (o_wa !== 8'(sent)) begin n_fail++; $display("FAIL wrap_wa: got %0h want %0h", o_wa, 8'(sent)); end
        if (o_di !== in_pd)    begin n_fail++; $display("FAIL wrap_di: got %0h want %0h", o_di, in_pd); end
        if (o_wa == 8'd0 && sent > 0) wa_wraps++;
        sent++;
      end
      if (o_re) begin
        n_tests++;
        if (o_ra !== 8'(reads)) begin n_fail++; $display("FAIL wrap_ra: got %0h want %0h", o_ra, 8'(reads)); end
        if (o_ra == 8'd0 && reads > 0) ra_wraps++;
        reads++;
      end
      if (o_pop) begin
        n_tests++;
        if (o_pd !== o_exp) begin n_fail++; $display("FAIL wrap_data: got %0h want %0h", o_pd, o_exp); end
        got++;
      end
      cyc++;
    end
    n_tests += 3;
    if (got != 600)    begin n_fail++; $display("FAIL wrap_words: got %0d want 600", got); end
    if (wa_wraps != 2) begin n_fail++; $display("FAIL wrap_wa_count: got %0d want 2", wa_wraps); end
    if (ra_wraps != 2) begin n_fail++; $display("FAIL wrap_ra_count: got %0d want 2", ra_wraps); end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    while (exp_q.size() < 100 && budget < 200) begin
      in_pd = 16'($urandom);
      observe();
      budget++;
    end
    n_tests++;
    if (exp_q.size() != 100) begin n_fail++; $display("FAIL mid_stored: got %0d want 100", exp_q.size()); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      observe();
      n_tests++;
      if (o_pd !== o_exp) begin n_fail++; $display("FAIL mid_pre_data: got %0h want %0h", o_pd, o_exp); end
    end
    rst = 1'b1; out_ready = 1'b0;
    observe();
    n_tests++;
    if (o_ore !== 1'b1) begin n_fail++; $display("FAIL mid_inflight_ore: got %b want 1", o_ore); end
    exp_q.delete();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0); in_pd = 16'h1234; out_ready = 1'b1;
      observe();
      n_tests += 2;
      if (o_out_valid !== (c == 4)) begin n_fail++; $display("FAIL mid_out_valid c%0d: got %b want %b", c, o_out_valid, c == 4); end
      if (o_cnt !== o_cnt_exp)      begin n_fail++; $display("FAIL mid_count c%0d: got %0d want %0d", c, o_cnt, o_cnt_exp); end
      if (c == 0) begin
        n_tests += 2;
        if (o_ore !== 1'b0) begin n_fail++; $display("FAIL mid_post_ore: got %b want 0", o_ore); end
        if (o_acc !== 1'b1) begin n_fail++; $display("FAIL mid_post_accept: got %b want 1", o_acc); end
      end
      if (c == 4) begin
        n_tests++;
        if (o_pd !== 16'h1234) begin n_fail++; $display("FAIL mid_post_data: got %0h want 1234", o_pd); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pd = 16'd0;
    test_reset();
    test_single();
    test_stream();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
